button_array: RTL and testbench

BUTTON_ARRAY -- requirements
Module: button_array

---
 rtl/button_array.sv | 187 ++++++++++++++++++
 tb/tb_button_array.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/button_array.sv
// Purpose: per-channel button conditioner (2-flop sync, debounce, press/release/long-press/auto-repeat events).
// Latency: 2 + DEBOUNCE_CYCLES edges from a btn change to level and its press/release pulse; every output is a flop.
// Backpressure: none; each pulse is high for exactly one cycle and must be taken when it appears.
//
// Ports:
//   clk            single clock, all state on its rising edge
//   reset          asynchronous, active-low
//   btn            raw asynchronous button levels, 1 = pressed
//   repeat_en      per-channel auto-repeat enable (synchronous to clk)
//   level          debounced button state
//   press_pulse    one cycle on accepted press and on every auto-repeat
//   release_pulse  one cycle on accepted release
//   long_pulse     one cycle when a press has been held LONG_CYCLES cycles
module button_array #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse
);

    // Each counter is wide enough to hold its parameter value, so no count
    // can ever wrap, however long a button is held.
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int RPT_W  = $clog2(REPEAT_CYCLES + 1);

    // Comparing against value-1 lets the event fire on the edge where the
    // count would reach the parameter value; the counter is cleared instead.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);
    localparam logic [RPT_W-1:0]  RPT_ONE   = RPT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // level 0
        DOWN = 2'd1,   // level 1, long press not yet reached
        HELD = 2'd2    // level 1, long press reached, auto-repeat active
    } state_t;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch

        logic              sync1;
        logic              sync2;
        logic              level_q;
        logic              level_d;
        logic [DB_W-1:0]   db_cnt;
        logic [DB_W-1:0]   db_cnt_d;
        logic              accept;
        logic              rise;
        logic              fall;
        state_t            state_q;
        state_t            state_d;
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_d;
        logic [RPT_W-1:0]  rpt_q;
        logic [RPT_W-1:0]  rpt_d;
        logic              press_q;
        logic              press_d;
        logic              rel_q;
        logic              rel_d;
        logic              long_q;
        logic              long_d;

        // Debounce: count consecutive cycles where the synchronized input
        // disagrees with the accepted level; any agreeing cycle restarts it.
        always_comb begin
            accept   = 1'b0;
            db_cnt_d = '0;
            if (sync2 != level_q) begin
                if (db_cnt == DB_LAST) begin
                    accept = 1'b1;
                end else begin
                    db_cnt_d = db_cnt + DB_ONE;
                end
            end
        end

        assign level_d = level_q ^ accept;
        // sync2 differs from level_q whenever accept is high, so sync2 gives
        // the direction of the accepted change.
        assign rise    = accept & sync2;
        assign fall    = accept & ~sync2;

        // Event FSM. It moves on the same edge as level, so each pulse is
        // high in the first cycle that level shows the new value.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            rpt_d   = rpt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            long_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = DOWN;
                        press_d = 1'b1;
                        hold_d  = '0;
                        rpt_d   = '0;
                    end
                end
                DOWN: begin
                    // Release is tested first, so a long event due on the
                    // same edge is dropped.
                    if (fall) begin
                        state_d = IDLE;
                        rel_d   = 1'b1;
                        hold_d  = '0;
                        rpt_d   = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        state_d = HELD;
                        long_d  = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        hold_d = hold_q + HOLD_ONE;
                    end
                end
                HELD: begin
                    // hold_q is frozen here; long_pulse cannot fire again
                    // until the button is released and pressed anew.
                    if (fall) begin
                        state_d = IDLE;
                        rel_d   = 1'b1;
                        hold_d  = '0;
                        rpt_d   = '0;
                    end else if (!repeat_en[g]) begin
                        // Parking at 0 makes a later enable wait a full period.
                        rpt_d = '0;
                    end else if (rpt_q == RPT_LAST) begin
                        press_d = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + RPT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                    rpt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1   <= 1'b0;
                sync2   <= 1'b0;
                level_q <= 1'b0;
                db_cnt  <= '0;
                state_q <= IDLE;
                hold_q  <= '0;
                rpt_q   <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                sync1   <= btn[g];
                sync2   <= sync1;
                level_q <= level_d;
                db_cnt  <= db_cnt_d;
                state_q <= state_d;
                hold_q  <= hold_d;
                rpt_q   <= rpt_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
            end
        end

        assign level[g]         = level_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = rel_q;
        assign long_pulse[g]    = long_q;
    end

endmodule

// File: tb/tb_button_array.sv
// Directed bench for button_array with N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3.
// Each scenario fills per-edge tables (btn drive and expected outputs), then steps the clock and compares.
// Edge k is the k-th rising edge of a scenario; btn for edge k is driven before that edge.
module tb_button_array;

    localparam int T_BTN = 0;
    localparam int T_LVL = 1;
    localparam int T_PRS = 2;
    localparam int T_REL = 3;
    localparam int T_LNG = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] btn;
    logic [1:0] repeat_en;
    logic [1:0] level;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] t_btn [0:63];
    logic [1:0] t_lvl [0:63];
    logic [1:0] t_prs [0:63];
    logic [1:0] t_rel [0:63];
    logic [1:0] t_lng [0:63];

    button_array #(
        .N_BTN          (2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (10),
        .REPEAT_CYCLES  (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .repeat_en    (repeat_en),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s edge=%0d observed={lvl,prs,rel,lng}=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic clear_tables();
        for (int k = 0; k < 64; k++) begin
            t_btn[k] = 2'b00;
            t_lvl[k] = 2'b00;
            t_prs[k] = 2'b00;
            t_rel[k] = 2'b00;
            t_lng[k] = 2'b00;
        end
    endtask

    task automatic fill(input int tbl, input int ch, input int a, input int b);
        for (int k = a; k <= b; k++) begin
            case (tbl)
                T_BTN:   t_btn[k][ch] = 1'b1;
                T_LVL:   t_lvl[k][ch] = 1'b1;
                T_PRS:   t_prs[k][ch] = 1'b1;
                T_REL:   t_rel[k][ch] = 1'b1;
                default: t_lng[k][ch] = 1'b1;
            endcase
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            btn = t_btn[k];
            @(posedge clk);
            #1;
            check(tag, k, {level, press_pulse, release_pulse, long_pulse},
                  {t_lvl[k], t_prs[k], t_rel[k], t_lng[k]});
        end
    endtask

    initial begin
        reset     = 1'b0;
        btn       = 2'b00;
        repeat_en = 2'b00;
        clear_tables();
        #12;
        check("reset_state", 0, {level, press_pulse, release_pulse, long_pulse}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Clean press, long press, repeats every 3, release landing on a due repeat.
        // Press at 6, long at 16, repeats 19..40; btn drops from edge 38 so
        // release is accepted at 43 where a repeat would also be due.
        clear_tables();
        repeat_en = 2'b01;
        fill(T_BTN, 0, 1, 37);
        fill(T_LVL, 0, 6, 42);
        fill(T_PRS, 0, 6, 6);
        fill(T_LNG, 0, 16, 16);
        for (int k = 19; k <= 40; k += 3) fill(T_PRS, 0, k, k);
        fill(T_REL, 0, 43, 43);
        run("long_repeat", 46);

        // Bounce: btn[0] toggles every 2 cycles for 20 cycles, then stays 0.
        clear_tables();
        repeat_en = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            if (((k - 1) / 2) % 2 == 0) fill(T_BTN, 0, k, k);
        end
        run("bounce", 28);

        // Same long hold with repeat disabled: long pulse only.
        clear_tables();
        repeat_en = 2'b00;
        fill(T_BTN, 0, 1, 30);
        fill(T_LVL, 0, 6, 35);
        fill(T_PRS, 0, 6, 6);
        fill(T_LNG, 0, 16, 16);
        fill(T_REL, 0, 36, 36);
        run("long_norepeat", 40);

        // Both channels pressed together; ch1 releases early and re-presses,
        // so its long pulse comes 14 edges after ch0's.
        clear_tables();
        repeat_en = 2'b00;
        fill(T_BTN, 0, 1, 32);
        fill(T_BTN, 1, 1, 8);
        fill(T_BTN, 1, 15, 32);
        fill(T_LVL, 0, 6, 37);
        fill(T_PRS, 0, 6, 6);
        fill(T_LNG, 0, 16, 16);
        fill(T_REL, 0, 38, 38);
        fill(T_LVL, 1, 6, 13);
        fill(T_LVL, 1, 20, 37);
        fill(T_PRS, 1, 6, 6);
        fill(T_REL, 1, 14, 14);
        fill(T_PRS, 1, 20, 20);
        fill(T_LNG, 1, 30, 30);
        fill(T_REL, 1, 38, 38);
        run("two_channels", 42);

        // Reset in the middle of a held press.
        clear_tables();
        repeat_en = 2'b01;
        fill(T_BTN, 0, 1, 20);
        fill(T_LVL, 0, 6, 20);
        fill(T_PRS, 0, 6, 6);
        fill(T_LNG, 0, 16, 16);
        fill(T_PRS, 0, 19, 19);
        run("pre_reset", 20);
        reset = 1'b0;
        #1;
        check("reset_async", 0, {level, press_pulse, release_pulse, long_pulse}, 8'h00);
        for (int j = 1; j <= 2; j++) begin
            @(posedge clk);
            #1;
            check("reset_held", j, {level, press_pulse, release_pulse, long_pulse}, 8'h00);
        end
        @(negedge clk);
        reset = 1'b1;

        // btn still high after reset: fresh press at 6, no release for the
        // aborted press. Release is accepted at 16, where long is also due.
        clear_tables();
        fill(T_BTN, 0, 1, 10);
        fill(T_LVL, 0, 6, 15);
        fill(T_PRS, 0, 6, 6);
        fill(T_REL, 0, 16, 16);
        run("post_reset", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
